// File: rtl/gpio_input_conditioner_if.sv
// Pin, event-flag and IRQ bundle between the board/CPU side and gpio_input_conditioner.
interface gpio_input_conditioner_if #(
  parameter int unsigned NUM_CH = 6
);
  logic [NUM_CH-1:0] PIN_IN;
  logic [NUM_CH-1:0] STATE_OUT;
  logic [NUM_CH-1:0] RISE_EVT;
  logic [NUM_CH-1:0] FALL_EVT;
  logic [NUM_CH-1:0] EVT_CLR;
  logic [NUM_CH-1:0] EVT_MASK;
  logic              IRQ;

  modport master (
    output PIN_IN, EVT_CLR, EVT_MASK,
    input  STATE_OUT, RISE_EVT, FALL_EVT, IRQ
  );

  modport slave (
    input  PIN_IN, EVT_CLR, EVT_MASK,
    output STATE_OUT, RISE_EVT, FALL_EVT, IRQ
  );
endinterface

// File: rtl/gpio_input_conditioner.sv
// Per-channel 2-FF sync, polarity normalisation, counter debounce, sticky W1C event flags, masked IRQ.
// Optional auto-repeat of RISE_EVT while held: define GPIO_AUTOREPEAT_EN.
module gpio_input_conditioner #(
  parameter int unsigned NUM_CH          = 6,
  parameter int unsigned DEBOUNCE_CYCLES = 251250,
  parameter int unsigned CNT_W           = 18,
  parameter int unsigned ACTIVE_LOW      = 1,
  parameter int unsigned REPEAT_DELAY    = 12562500,
  parameter int unsigned REPEAT_RATE     = 2512500
) (
  input  logic                     CLK,
  input  logic                     RSTb,
  gpio_input_conditioner_if.slave  bus
);

  typedef enum logic {ST_STABLE, ST_QUALIFY} deb_state_t;

  localparam logic             POL      = (ACTIVE_LOW != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_CH-1:0] r_s1, r_s2, w_level;
  logic [NUM_CH-1:0] r_state, w_state_nxt;
  logic [NUM_CH-1:0] r_rise, r_fall;
  logic [NUM_CH-1:0] w_rise_set, w_fall_set, w_rise_evt;
  logic              r_irq;
  deb_state_t        r_st      [NUM_CH];
  deb_state_t        w_st_nxt  [NUM_CH];
  logic [CNT_W-1:0]  r_cnt     [NUM_CH];
  logic [CNT_W-1:0]  w_cnt_nxt [NUM_CH];

  // Sync flops idle at the de-asserted pin level so reset never looks like a press.
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      r_s1 <= {NUM_CH{POL}};
      r_s2 <= {NUM_CH{POL}};
    end else begin
      r_s1 <= bus.PIN_IN;
      r_s2 <= r_s1;
    end
  end

  assign w_level = r_s2 ^ {NUM_CH{POL}};

  always_comb begin
    w_state_nxt = r_state;
    w_rise_set  = '0;
    w_fall_set  = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      w_st_nxt[i]  = r_st[i];
      w_cnt_nxt[i] = r_cnt[i];
      case (r_st[i])
        ST_STABLE: begin
          if (w_level[i] != r_state[i]) begin
            w_cnt_nxt[i] = CNT_W'(1);
            w_st_nxt[i]  = ST_QUALIFY;
          end
        end
        ST_QUALIFY: begin
          if (w_level[i] == r_state[i]) begin
            w_cnt_nxt[i] = '0;
            w_st_nxt[i]  = ST_STABLE;
          end else if (r_cnt[i] == CNT_LAST) begin
            w_state_nxt[i] = w_level[i];
            w_rise_set[i]  = w_level[i];
            w_fall_set[i]  = ~w_level[i];
            w_cnt_nxt[i]   = '0;
            w_st_nxt[i]    = ST_STABLE;
          end else begin
            w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
          end
        end
        default: begin
          w_cnt_nxt[i] = '0;
          w_st_nxt[i]  = ST_STABLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        r_st[i]  <= ST_STABLE;
        r_cnt[i] <= '0;
      end
      r_state <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        r_st[i]  <= w_st_nxt[i];
        r_cnt[i] <= w_cnt_nxt[i];
      end
      r_state <= w_state_nxt;
    end
  end

`ifdef GPIO_AUTOREPEAT_EN
  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned HOLD_W  = $clog2(REP_MAX + 1);
  localparam logic [HOLD_W-1:0] DELAY_LAST = HOLD_W'(REPEAT_DELAY - 1);
  localparam logic [HOLD_W-1:0] RATE_LAST  = HOLD_W'(REPEAT_RATE - 1);

  logic [HOLD_W-1:0] r_hold [NUM_CH];
  logic [NUM_CH-1:0] r_rep, w_rep_fire;

  always_comb begin
    w_rep_fire = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      w_rep_fire[i] = r_state[i] & w_state_nxt[i] &
                      (r_hold[i] == (r_rep[i] ? RATE_LAST : DELAY_LAST));
    end
  end

  // r_rep selects the first-delay threshold versus the steady repeat interval.
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      for (int unsigned i = 0; i < NUM_CH; i++) r_hold[i] <= '0;
      r_rep <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (!r_state[i] || !w_state_nxt[i]) begin
          r_hold[i] <= '0;
          r_rep[i]  <= 1'b0;
        end else if (w_rep_fire[i]) begin
          r_hold[i] <= '0;
          r_rep[i]  <= 1'b1;
        end else begin
          r_hold[i] <= r_hold[i] + HOLD_W'(1);
        end
      end
    end
  end

  assign w_rise_evt = w_rise_set | w_rep_fire;
`else
  // Repeat timing has no effect in this build; the mask below is constant all-ones.
  assign w_rise_evt = w_rise_set & {NUM_CH{(REPEAT_DELAY | REPEAT_RATE | 1) != 0}};
`endif

  // Set has priority over clear so an event coinciding with EVT_CLR is kept.
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      r_rise <= '0;
      r_fall <= '0;
      r_irq  <= 1'b0;
    end else begin
      r_rise <= (r_rise & ~bus.EVT_CLR) | w_rise_evt;
      r_fall <= (r_fall & ~bus.EVT_CLR) | w_fall_set;
      r_irq  <= |((r_rise | r_fall) & bus.EVT_MASK);
    end
  end

  assign bus.STATE_OUT = r_state;
  assign bus.RISE_EVT  = r_rise;
  assign bus.FALL_EVT  = r_fall;
  assign bus.IRQ       = r_irq;

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Directed bench for gpio_input_conditioner: 2 channels, 8-cycle debounce, active-low pins.
module tb_gpio_input_conditioner;

  logic CLK = 1'b0;
  logic RSTb;
  int   checks   = 0;
  int   failures = 0;

  always #5 CLK = ~CLK;

  gpio_input_conditioner_if #(.NUM_CH(2)) gif ();

  gpio_input_conditioner #(
    .NUM_CH(2), .DEBOUNCE_CYCLES(8), .CNT_W(4), .ACTIVE_LOW(1),
    .REPEAT_DELAY(20), .REPEAT_RATE(6)
  ) dut (
    .CLK (CLK),
    .RSTb(RSTb),
    .bus (gif.slave)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    RSTb         = 1'b0;
    gif.PIN_IN   = 2'b11;
    gif.EVT_CLR  = 2'b00;
    gif.EVT_MASK = 2'b01;

    // Reset values
    tick(); tick(); tick();
    chk("rst_state", 8'(gif.STATE_OUT), 8'h0);
    chk("rst_rise",  8'(gif.RISE_EVT),  8'h0);
    chk("rst_fall",  8'(gif.FALL_EVT),  8'h0);
    chk("rst_irq",   8'(gif.IRQ),       8'h0);
    RSTb = 1'b1;
    tick(); tick(); tick();
    chk("idle_state", 8'(gif.STATE_OUT), 8'h0);

    // Debounced press on ch0: visible on the 10th edge, IRQ one edge later
    gif.PIN_IN = 2'b10;
    for (int i = 1; i <= 9; i++) tick();
    chk("press_e9_state", 8'(gif.STATE_OUT), 8'h0);
    chk("press_e9_rise",  8'(gif.RISE_EVT),  8'h0);
    tick();
    chk("press_e10_state", 8'(gif.STATE_OUT), 8'h1);
    chk("press_e10_rise",  8'(gif.RISE_EVT),  8'h1);
    chk("press_e10_irq",   8'(gif.IRQ),       8'h0);
    tick();
    chk("press_e11_irq",   8'(gif.IRQ),       8'h1);

    // W1C clear: flag drops on the clear edge, IRQ one edge after
    gif.EVT_CLR = 2'b01;
    tick();
    gif.EVT_CLR = 2'b00;
    chk("clr_rise", 8'(gif.RISE_EVT), 8'h0);
    chk("clr_irq_lag", 8'(gif.IRQ), 8'h1);
    tick();
    chk("clr_irq", 8'(gif.IRQ), 8'h0);

    // Release ch0 with EVT_CLR on the same edge the FALL flag sets: set wins
    gif.PIN_IN = 2'b11;
    for (int i = 1; i <= 9; i++) tick();
    chk("rel_e9_fall",  8'(gif.FALL_EVT),  8'h0);
    chk("rel_e9_state", 8'(gif.STATE_OUT), 8'h1);
    gif.EVT_CLR = 2'b11;
    tick();
    gif.EVT_CLR = 2'b00;
    chk("setwins_fall",  8'(gif.FALL_EVT),  8'h1);
    chk("setwins_rise",  8'(gif.RISE_EVT),  8'h0);
    chk("setwins_state", 8'(gif.STATE_OUT), 8'h0);
    tick();
    chk("fall_irq", 8'(gif.IRQ), 8'h1);

    // Mask gates IRQ only; unmask with pending flag re-raises next edge
    gif.EVT_MASK = 2'b00;
    tick();
    chk("mask_irq",  8'(gif.IRQ),      8'h0);
    chk("mask_fall", 8'(gif.FALL_EVT), 8'h1);
    gif.EVT_MASK = 2'b01;
    tick();
    chk("unmask_irq", 8'(gif.IRQ), 8'h1);

    // Clear held for two cycles
    gif.EVT_CLR = 2'b01;
    tick(); tick();
    gif.EVT_CLR = 2'b00;
    chk("hold_clr_fall", 8'(gif.FALL_EVT), 8'h0);
    tick();
    chk("hold_clr_irq", 8'(gif.IRQ), 8'h0);

    // 7-cycle glitch on ch1 is rejected
    gif.EVT_MASK = 2'b11;
    gif.PIN_IN   = 2'b01;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 7) gif.PIN_IN = 2'b11;
      chk("glitch_state", 8'(gif.STATE_OUT), 8'h0);
      chk("glitch_flags", 8'({gif.RISE_EVT, gif.FALL_EVT}), 8'h0);
      chk("glitch_irq",   8'(gif.IRQ), 8'h0);
    end

    // Simultaneous press on both channels latches on one edge
    gif.PIN_IN = 2'b00;
    for (int i = 1; i <= 9; i++) tick();
    chk("both_e9_rise", 8'(gif.RISE_EVT), 8'h0);
    tick();
    chk("both_e10_rise",  8'(gif.RISE_EVT),  8'h3);
    chk("both_e10_state", 8'(gif.STATE_OUT), 8'h3);
    gif.EVT_CLR = 2'b11;
    gif.PIN_IN  = 2'b11;
    tick();
    gif.EVT_CLR = 2'b00;
    chk("both_clr", 8'(gif.RISE_EVT), 8'h0);
    for (int i = 2; i <= 10; i++) tick();
    chk("both_fall", 8'(gif.FALL_EVT), 8'h3);
    gif.EVT_CLR = 2'b11;
    tick();
    gif.EVT_CLR = 2'b00;
    chk("both_fall_clr", 8'(gif.FALL_EVT), 8'h0);
    gif.EVT_MASK = 2'b01;
    tick(); tick();

    // Reset in mid-qualification aborts; re-qualifies from scratch
    gif.PIN_IN = 2'b10;
    for (int i = 1; i <= 5; i++) tick();
    chk("midq_rise", 8'(gif.RISE_EVT), 8'h0);
    RSTb = 1'b0;
    #1;
    chk("midq_rst_state", 8'(gif.STATE_OUT), 8'h0);
    tick(); tick();
    RSTb = 1'b1;
    for (int i = 1; i <= 9; i++) tick();
    chk("midq_e9_rise", 8'(gif.RISE_EVT), 8'h0);
    tick();
    chk("midq_e10_rise",  8'(gif.RISE_EVT),  8'h1);
    chk("midq_e10_state", 8'(gif.STATE_OUT), 8'h1);

`ifdef GPIO_AUTOREPEAT_EN
    // Auto-repeat: k counts edges after STATE_OUT[0] rose; first at 20, then every 6
    begin
      logic rep_prev;
      logic exp_r;
      rep_prev = 1'b0;
      for (int k = 1; k <= 60; k++) begin
        gif.EVT_CLR = (k == 1 || rep_prev) ? 2'b01 : 2'b00;
        if (k == 42) gif.PIN_IN = 2'b11;
        tick();
        exp_r = (k >= 20) && (((k - 20) % 6) == 0) && (k < 51);
        chk("rep_rise", 8'(gif.RISE_EVT[0]), 8'(exp_r));
        chk("rep_fall", 8'(gif.FALL_EVT[0]), 8'(k >= 51));
        rep_prev = exp_r;
      end
      gif.EVT_CLR = 2'b00;
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
